// File: rtl/cache_2way_param.sv
// 2-way set-associative write-back/write-allocate data cache with true-LRU
// replacement per set and saturating hit/miss performance counters.
module cache_2way_param #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int WORDS  = 4,
    parameter int SETS   = 4,
    parameter int CNT_W  = 32
) (
    input  logic                              clk,
    input  logic                              proc_reset,
    input  logic                              proc_read,
    input  logic                              proc_write,
    input  logic [ADDR_W-1:0]                 proc_addr,
    input  logic [DATA_W-1:0]                 proc_wdata,
    output logic [DATA_W-1:0]                 proc_rdata,
    output logic                              proc_stall,
    output logic                              mem_read,
    output logic                              mem_write,
    output logic [ADDR_W-$clog2(WORDS)-1:0]   mem_addr,
    output logic [DATA_W*WORDS-1:0]           mem_wdata,
    input  logic [DATA_W*WORDS-1:0]           mem_rdata,
    input  logic                              mem_ready,
    output logic [CNT_W-1:0]                  hit_cnt,
    output logic [CNT_W-1:0]                  miss_cnt
);
    localparam int OFF_W  = $clog2(WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W = DATA_W * WORDS;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WRITE_BACK = 2'd1;
    localparam logic [1:0] ST_ALLOCATE   = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [SETS-1:0]   valid [2];
    logic [SETS-1:0]   dirty [2];
    logic [SETS-1:0]   lru;
    logic [TAG_W-1:0]  tags  [2][SETS];
    logic [LINE_W-1:0] lines [2][SETS];
    logic              victim;
    logic              victim_next;
    logic              victim_dirty;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  idx;
    logic [OFF_W-1:0]  off;
    logic              request;
    logic              hit0;
    logic              hit1;
    logic              hit;
    logic              hit_way;
    logic              idle_hit;
    logic              idle_miss;
    logic              refill;
    logic [LINE_W-1:0] hit_line;

    assign req_tag   = proc_addr[ADDR_W-1 -: TAG_W];
    assign idx       = proc_addr[OFF_W +: IDX_W];
    assign off       = proc_addr[OFF_W-1:0];
    assign request   = proc_read | proc_write;
    assign hit0      = valid[0][idx] && (tags[0][idx] == req_tag);
    assign hit1      = valid[1][idx] && (tags[1][idx] == req_tag);
    assign hit       = hit0 | hit1;
    assign hit_way   = hit1;
    assign idle_hit  = (state == ST_IDLE) && request && hit;
    assign idle_miss = (state == ST_IDLE) && request && !hit;
    assign refill    = (state == ST_ALLOCATE) && mem_ready;
    assign hit_line  = lines[hit_way][idx];

    // Victim choice, next state and the combinational processor/memory outputs.
    always_comb begin
        if (!valid[0][idx]) begin
            victim_next = 1'b0;
        end else if (!valid[1][idx]) begin
            victim_next = 1'b1;
        end else begin
            victim_next = lru[idx];
        end
        victim_dirty = valid[victim_next][idx] && dirty[victim_next][idx];

        state_next = state;
        proc_stall = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = proc_addr[ADDR_W-1:OFF_W];
        mem_wdata  = lines[victim][idx];
        if (hit) begin
            proc_rdata = hit_line[off*DATA_W +: DATA_W];
        end else begin
            proc_rdata = {DATA_W{1'b0}};
        end

        case (state)
            ST_IDLE: begin
                if (request && !hit) begin
                    proc_stall = 1'b1;
                    state_next = victim_dirty ? ST_WRITE_BACK : ST_ALLOCATE;
                end else begin
                    proc_stall = 1'b0;
                end
            end
            ST_WRITE_BACK: begin
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {tags[victim][idx], idx};
                if (mem_ready) begin
                    state_next = ST_ALLOCATE;
                end else begin
                    state_next = ST_WRITE_BACK;
                end
            end
            ST_ALLOCATE: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                if (mem_ready) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_ALLOCATE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Control state: FSM, valid/dirty/lru bits, victim register and counters.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state    <= ST_IDLE;
            valid[0] <= {SETS{1'b0}};
            valid[1] <= {SETS{1'b0}};
            dirty[0] <= {SETS{1'b0}};
            dirty[1] <= {SETS{1'b0}};
            lru      <= {SETS{1'b0}};
            victim   <= 1'b0;
            hit_cnt  <= {CNT_W{1'b0}};
            miss_cnt <= {CNT_W{1'b0}};
        end else begin
            state <= state_next;
            if (idle_hit) begin
                lru[idx] <= ~hit_way;
                if (proc_write) begin
                    dirty[hit_way][idx] <= 1'b1;
                end
                if (hit_cnt != CNT_MAX) begin
                    hit_cnt <= hit_cnt + CNT_ONE;
                end
            end
            if (idle_miss) begin
                victim <= victim_next;
                if (miss_cnt != CNT_MAX) begin
                    miss_cnt <= miss_cnt + CNT_ONE;
                end
            end
            if (refill) begin
                valid[victim][idx] <= 1'b1;
                dirty[victim][idx] <= 1'b0;
            end
        end
    end

    // Line and tag storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (!proc_reset) begin
            if (refill) begin
                lines[victim][idx] <= mem_rdata;
                tags[victim][idx]  <= req_tag;
            end else if (idle_hit && proc_write) begin
                lines[hit_way][idx][off*DATA_W +: DATA_W] <= proc_wdata;
            end
        end
    end

endmodule

// File: tb/tb_cache_2way_param.sv
// Directed bench for cache_2way_param: a transaction-level cache/memory model
// sets per-cycle expectations that one negedge process compares against two DUTs.
module tb_cache_2way_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         proc_reset, proc_read, proc_write, mem_ready;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata, proc_rdata, rdata4, hit_cnt, miss_cnt;
    logic         proc_stall, mem_read, mem_write, stall4, mrd4, mwr4;
    logic [27:0]  mem_addr, maddr4;
    logic [127:0] mem_wdata, mem_rdata, mwdata4;
    logic [3:0]   hit_cnt4, miss_cnt4;

    cache_2way_param dut (
        .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(proc_rdata),
        .proc_stall(proc_stall), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    cache_2way_param #(.CNT_W(4)) dut4 (
        .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(rdata4),
        .proc_stall(stall4), .mem_read(mrd4), .mem_write(mwr4),
        .mem_addr(maddr4), .mem_wdata(mwdata4), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .hit_cnt(hit_cnt4), .miss_cnt(miss_cnt4)
    );

    int compared = 0;
    int mismatched = 0;

    // Model of cache contents, backing memory and counters.
    bit           mv [4][2];
    bit           md [4][2];
    bit           mlru [4];
    logic [25:0]  mt [4][2];
    logic [127:0] mdat [4][2];
    logic [127:0] mem_store [logic [27:0]];
    int           mh, mm;

    // Per-cycle expectations, written by the stimulus, read by the comparer.
    logic         chk_en, exp_stall, exp_mrd, exp_mwr, exp_rvalid;
    logic [27:0]  exp_maddr;
    logic [127:0] exp_mwdata;
    logic [31:0]  exp_rdata;

    // Observations for hand-computed checks.
    int           wb_cycles = 0;
    logic [27:0]  seen_wb_addr, seen_rd_addr;
    logic [127:0] seen_wb_line;
    bit           seen_rd = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] get_line(input logic [27:0] la);
        if (mem_store.exists(la)) return mem_store[la];
        return {4'd3, la, 4'd2, la, 4'd1, la, 4'd0, la};
    endfunction

    function automatic int sat4(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    // Single compare process: every cycle the outputs are meaningful.
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", proc_stall, exp_stall);
            check("stall4", stall4, exp_stall);
            check("mem_read", mem_read, exp_mrd);
            check("mem_write", mem_write, exp_mwr);
            check("mem_rw4", {mrd4, mwr4}, {exp_mrd, exp_mwr});
            if (exp_mrd || exp_mwr) check("mem_addr", mem_addr, exp_maddr);
            if (exp_mwr) check("mem_wdata", mem_wdata, exp_mwdata);
            if (exp_rvalid) check("rdata", proc_rdata, exp_rdata);
            if (exp_rvalid) check("rdata4", rdata4, exp_rdata);
            check("hit_cnt", hit_cnt, mh);
            check("miss_cnt", miss_cnt, mm);
            check("hit_cnt4", hit_cnt4, sat4(mh));
            check("miss_cnt4", miss_cnt4, sat4(mm));
            if (mem_write) begin
                wb_cycles++;
                seen_wb_addr = mem_addr;
                seen_wb_line = mem_wdata;
            end
            if (mem_read && !seen_rd) begin
                seen_rd = 1'b1;
                seen_rd_addr = mem_addr;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_expect();
        exp_stall = 1'b0; exp_mrd = 1'b0; exp_mwr = 1'b0; exp_rvalid = 1'b0;
    endtask

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            mlru[s] = 1'b0;
            for (int w = 0; w < 2; w++) begin
                mv[s][w] = 1'b0;
                md[s][w] = 1'b0;
            end
        end
        mh = 0;
        mm = 0;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        proc_reset = 1'b1; proc_read = 1'b0; proc_write = 1'b0; mem_ready = 1'b0;
        cyc();
        cyc();
        check("rst_stall", proc_stall, 1'b0);
        check("rst_mem_rw", {mem_read, mem_write}, 2'b00);
        check("rst_counters", {hit_cnt, miss_cnt}, 64'd0);
        proc_reset = 1'b0;
        model_reset();
        idle_expect();
        chk_en = 1'b1;
    endtask

    // One processor request to completion, then one idle cycle.
    task automatic access(input logic wr, input logic [29:0] a, input logic [31:0] wd,
                          input int wb_wait, input int al_wait,
                          output logic [31:0] got, output logic was_hit);
        int s, o, hw, v;
        logic [25:0] t;
        logic [27:0] la;
        s = int'(a[3:2]); o = int'(a[1:0]); t = a[29:4]; la = a[29:2];
        proc_read = !wr; proc_write = wr; proc_addr = a; proc_wdata = wd;
        hw = -1;
        for (int w = 0; w < 2; w++) if (mv[s][w] && mt[s][w] == t) hw = w;
        was_hit = (hw >= 0);
        if (hw < 0) begin
            exp_stall = 1'b1; exp_mrd = 1'b0; exp_mwr = 1'b0; exp_rvalid = 1'b0;
            cyc();
            mm++;
            v = !mv[s][0] ? 0 : (!mv[s][1] ? 1 : int'(mlru[s]));
            if (mv[s][v] && md[s][v]) begin
                exp_mwr = 1'b1; exp_maddr = {mt[s][v], 2'(s)}; exp_mwdata = mdat[s][v];
                for (int i = 0; i <= wb_wait; i++) begin
                    mem_ready = (i == wb_wait);
                    cyc();
                end
                mem_ready = 1'b0; exp_mwr = 1'b0;
                mem_store[exp_maddr] = mdat[s][v];
            end
            exp_mrd = 1'b1; exp_maddr = la; mem_rdata = get_line(la);
            for (int i = 0; i <= al_wait; i++) begin
                mem_ready = (i == al_wait);
                cyc();
            end
            mem_ready = 1'b0; exp_mrd = 1'b0;
            mv[s][v] = 1'b1; md[s][v] = 1'b0; mt[s][v] = t; mdat[s][v] = mem_rdata;
            hw = v;
        end
        exp_stall = 1'b0;
        exp_rvalid = !wr;
        exp_rdata = mdat[s][hw][o*32 +: 32];
        @(negedge clk);
        got = proc_rdata;
        cyc();
        if (wr) begin
            mdat[s][hw][o*32 +: 32] = wd;
            md[s][hw] = 1'b1;
        end
        mlru[s] = (hw == 0);
        mh++;
        proc_read = 1'b0; proc_write = 1'b0;
        idle_expect();
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic wh;
        int wb_before;
        proc_reset = 1'b0; proc_read = 1'b0; proc_write = 1'b0; mem_ready = 1'b0;
        proc_addr = 30'd0; proc_wdata = 32'd0; mem_rdata = 128'd0;
        chk_en = 1'b0;
        idle_expect();
        exp_maddr = 28'd0; exp_mwdata = 128'd0; exp_rdata = 32'd0;
        mem_store[28'h4] = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
        do_reset();

        // Cold miss then hits on the refilled line.
        access(1'b0, 30'h10, 32'd0, 0, 1, got, wh);
        check("t1_first_is_miss", wh, 1'b0);
        check("t1_alloc_addr", seen_rd_addr, 28'h4);
        check("t1_word0", got, 32'h00000000);
        check("t1_hit_cnt", hit_cnt, 32'd1);
        check("t1_miss_cnt", miss_cnt, 32'd1);
        access(1'b0, 30'h11, 32'd0, 0, 0, got, wh);
        check("t1_word1", got, 32'h11111111);

        // Write hit and readback.
        access(1'b1, 30'h12, 32'hDEADBEEF, 0, 0, got, wh);
        check("t2_write_hit", wh, 1'b1);
        access(1'b0, 30'h12, 32'd0, 0, 0, got, wh);
        check("t2_readback", got, 32'hDEADBEEF);

        // LRU eviction of a clean line.
        do_reset();
        access(1'b0, 30'h00, 32'd0, 0, 0, got, wh);
        access(1'b0, 30'h10, 32'd0, 0, 0, got, wh);
        access(1'b0, 30'h00, 32'd0, 0, 0, got, wh);
        wb_before = wb_cycles;
        access(1'b0, 30'h20, 32'd0, 0, 2, got, wh);
        check("t3_clean_no_wb", wb_cycles, wb_before);
        access(1'b0, 30'h00, 32'd0, 0, 0, got, wh);
        check("t3_mru_kept", wh, 1'b1);
        access(1'b0, 30'h10, 32'd0, 0, 0, got, wh);
        check("t3_lru_evicted", wh, 1'b0);

        // Dirty eviction with a 3-cycle write-back.
        do_reset();
        access(1'b0, 30'h10, 32'd0, 0, 0, got, wh);
        access(1'b1, 30'h10, 32'hCAFEF00D, 0, 0, got, wh);
        access(1'b0, 30'h20, 32'd0, 0, 0, got, wh);
        wb_before = wb_cycles;
        access(1'b0, 30'h30, 32'd0, 2, 1, got, wh);
        check("t4_wb_cycles", wb_cycles - wb_before, 3);
        check("t4_wb_addr", seen_wb_addr, 28'h4);
        check("t4_wb_word0", seen_wb_line[31:0], 32'hCAFEF00D);
        check("t4_wb_word1", seen_wb_line[63:32], 32'h11111111);
        access(1'b0, 30'h10, 32'd0, 0, 0, got, wh);
        check("t4_refetch", got, 32'hCAFEF00D);

        // Reset in the middle of ALLOCATE.
        proc_read = 1'b1; proc_addr = 30'h24;
        exp_stall = 1'b1; exp_mrd = 1'b0; exp_mwr = 1'b0; exp_rvalid = 1'b0;
        cyc();
        mm++;
        exp_mrd = 1'b1; exp_maddr = 28'h9; mem_rdata = get_line(28'h9);
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        proc_reset = 1'b1; proc_read = 1'b0;
        #1;
        check("t5_rst_mem_read", mem_read, 1'b0);
        check("t5_rst_stall", proc_stall, 1'b0);
        check("t5_rst_miss_cnt", miss_cnt, 32'd0);
        check("t5_rst_hit_cnt", hit_cnt, 32'd0);
        @(posedge clk);
        #1;
        proc_reset = 1'b0;
        model_reset();
        idle_expect();
        chk_en = 1'b1;
        access(1'b0, 30'h24, 32'd0, 0, 0, got, wh);
        check("t5_miss_again", wh, 1'b0);
        check("t5_miss_cnt", miss_cnt, 32'd1);

        // Counter saturation on the 4-bit instance.
        do_reset();
        access(1'b0, 30'h00, 32'd0, 0, 0, got, wh);
        for (int i = 0; i < 17; i++) access(1'b0, 30'(i % 4), 32'd0, 0, 0, got, wh);
        check("t6_hit_cnt4_sat", hit_cnt4, 4'hF);
        check("t6_hit_cnt", hit_cnt, 32'd18);
        check("t6_miss_cnt4", miss_cnt4, 4'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/cache_2way_param.md
Name: cache_2way_param

Overview:
- Parametrised 2-way set-associative, write-back, write-allocate data cache with true-LRU replacement per set.
- Sits between the pipeline MEM stage (word-addressed processor port) and the line-wide memory port of the 5-stage RISC-V core.
- Adds a configurable set count, line length and data width, plus saturating hit/miss performance counters.

Parameters:
- ADDR_W, 30, processor word-address width.
- DATA_W, 32, word width.
- WORDS, 4, words per line (power of 2, >=2); OFF_W = log2(WORDS).
- SETS, 4, number of sets (power of 2, >=2); IDX_W = log2(SETS); TAG_W = ADDR_W-IDX_W-OFF_W.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- proc_reset  in  1  asynchronous, active-high reset.
- proc_read  in  1  read request.
- proc_write  in  1  write request (wins if both high).
- proc_addr  in  ADDR_W  word address {tag, index, offset}.
- proc_wdata  in  DATA_W  write data.
- proc_rdata  out  DATA_W  read data, valid when request high and stall low.
- proc_stall  out  1  request not complete; processor holds addr/data/request stable.
- mem_read  out  1  line read request.
- mem_write  out  1  line write request.
- mem_addr  out  ADDR_W-OFF_W  line address.
- mem_wdata  out  DATA_W*WORDS  write line; word k at bits [k*DATA_W +: DATA_W].
- mem_rdata  in  DATA_W*WORDS  read line, same packing.
- mem_ready  in  1  one-cycle completion pulse for the current mem request.
- hit_cnt  out  CNT_W  saturating hit count.
- miss_cnt  out  CNT_W  saturating miss count.

Behaviour:
- Storage per set and way: valid, dirty, tag, WORDS data words. Per set: lru bit, which names the least-recently-used way.
- Reset (async): state=IDLE; all valid, dirty and lru bits 0; counters 0; mem_read=0, mem_write=0, proc_stall=0. Data and tag arrays need no reset. Reset mid-transaction abandons it with no array update.
- Hit: a way in the indexed set is valid and its tag matches. Both ways never hit simultaneously.
- IDLE, no request: stall=0, no memory activity.
- IDLE, hit:
  - stall=0 combinationally.
  - Read: proc_rdata = hit way word[offset], combinational.
  - Write: at the clock edge, word[offset] <= proc_wdata and dirty <= 1.
  - Either case: lru <= other way; hit_cnt += 1.
- IDLE, miss:
  - stall=1; miss_cnt += 1.
  - Victim register <= way0 if invalid, else way1 if invalid, else lru.
  - Next state is WRITE_BACK if the victim is valid and dirty, else ALLOCATE.
  - mem_read and mem_write stay 0 in IDLE.
- WRITE_BACK:
  - stall=1, mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim line, all held stable.
  - On mem_ready: state <= ALLOCATE.
- ALLOCATE:
  - stall=1, mem_read=1, mem_addr=proc_addr[ADDR_W-1:OFF_W].
  - On mem_ready, the victim way receives line <= mem_rdata, tag <= proc tag, valid <= 1, dirty <= 0; state <= IDLE.
- Next IDLE cycle after refill: the request is re-evaluated, hits, completes, and counts as a hit.
- Clean-miss latency: 1 + N + 1 cycles, where N = cycles in ALLOCATE. A dirty miss adds the WRITE_BACK cycles.
- mem_read and mem_write are never asserted together. mem_ready is ignored in IDLE.
- Counters stop at 2^CNT_W-1 and do not wrap.
- Request dropped during WRITE_BACK/ALLOCATE: illegal. The transaction still completes its memory handshake.

Test Plan (default parameters: index=addr[3:2], offset=addr[1:0]):
- Reset, read 0x10 -> stall=1, ALLOCATE with mem_read=1, mem_addr=0x4. Return mem_ready with line {D3,D2,D1,D0}=0x33..,0x22..,0x11..,0x00.. -> next cycle stall=0, rdata=0x11.. for addr 0x11; miss_cnt=1, hit_cnt=1.
- Write 0xDEADBEEF to 0x12 (hit) -> no stall, no mem access. A later read of 0x12 returns 0xDEADBEEF; dirty set.
- Fill set 0 with 0x00 and 0x10, touch 0x00, read 0x20 -> the way holding 0x10 is evicted (LRU). A clean victim gives no mem_write. Re-reading 0x00 hits.
- Dirty eviction: write 0x10, then miss to 0x20 and 0x30 so 0x10 is victim -> mem_write=1, mem_addr=0x4, mem_wdata contains the written word. Held 3 cycles until mem_ready, then mem_read to the new line.
- Assert proc_reset mid-ALLOCATE -> mem_read drops immediately, stall=0, counters 0. Re-reading the same address misses again.
- Force counters to all-ones with CNT_W=4 (16+ hits) -> hit_cnt stays 0xF.
